// File: rtl/jtag_dtm_param.sv
// JTAG debug transport module: IEEE 1149.1 TAP with IDCODE, DTMCS, DMI and BYPASS
// data registers, bridging DMI scans onto a valid/ready request/response bus.
module jtag_dtm_param #(
    parameter int          IR_WIDTH   = 5,
    parameter int          ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
    parameter int          IDLE_HINT  = 5
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);

    localparam int DRW = ABITS + 34;
    localparam int LW  = $clog2(DRW);

    localparam logic [31:0]         IDCODE_FIX = IDCODE_VAL | 32'h0000_0001;
    localparam logic [5:0]          ABITS6     = 6'(ABITS);
    localparam logic [2:0]          IDLE3      = 3'(IDLE_HINT);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS   = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_DMI     = IR_WIDTH'(5'h11);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_t;

    tap_t                state, state_next;
    dr_sel_t             dr_sel;
    logic [IR_WIDTH-1:0] ir, ir_sh;
    logic [DRW-1:0]      dr_sh, dr_next, cap_val;
    logic [LW-1:0]       dr_msb;

    logic        outstanding, req_accepted;
    logic [1:0]  dmistat, dmistat_next, dmistat_base;
    logic [31:0] resp_data;

    logic upd_dtmcs, upd_dmi, cap_dmi;
    logic dmireset, hardreset, busy_evt, resp_hs, fail_evt, start;

    // TAP controller
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state <= TLR;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:    state_next = TMS ? TLR    : RTI;
            RTI:    state_next = TMS ? SEL_DR : RTI;
            SEL_DR: state_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_next = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_next = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_next = TMS ? UPD_DR : PA_DR;
            PA_DR:  state_next = TMS ? EX2_DR : PA_DR;
            EX2_DR: state_next = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_next = TMS ? SEL_DR : RTI;
            SEL_IR: state_next = TMS ? TLR    : CAP_IR;
            CAP_IR: state_next = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_next = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_next = TMS ? UPD_IR : PA_IR;
            PA_IR:  state_next = TMS ? EX2_IR : PA_IR;
            EX2_IR: state_next = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_next = TMS ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // Instruction register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir    <= IR_IDCODE;
            ir_sh <= '0;
        end else begin
            if (state == TLR)    ir <= IR_IDCODE;
            if (state == UPD_IR) ir <= ir_sh;
            if (state == CAP_IR) ir_sh <= IR_CAPTURE;
            else if (state == SH_IR) ir_sh <= {TDI, ir_sh[IR_WIDTH-1:1]};
        end
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        dr_msb = '0;
        if (ir == IR_IDCODE) begin
            dr_sel = DR_IDCODE;
            dr_msb = LW'(31);
        end else if (ir == IR_DTMCS) begin
            dr_sel = DR_DTMCS;
            dr_msb = LW'(31);
        end else if (ir == IR_DMI) begin
            dr_sel = DR_DMI;
            dr_msb = LW'(DRW - 1);
        end
    end

    // Capture values; a DMI capture during an outstanding request reports busy
    always_comb begin
        cap_val = '0;
        case (dr_sel)
            DR_IDCODE: cap_val = DRW'(IDCODE_FIX);
            DR_DTMCS:  cap_val = DRW'({14'b0, 1'b0, 1'b0, 1'b0, IDLE3, dmistat, ABITS6, 4'd1});
            DR_DMI:    cap_val = {dmi_req_addr, resp_data, (outstanding ? 2'd3 : dmistat)};
            default:   cap_val = '0;
        endcase
    end

    always_comb begin
        dr_next         = dr_sh >> 1;
        dr_next[dr_msb] = TDI;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)                 dr_sh <= '0;
        else if (state == CAP_DR) dr_sh <= cap_val;
        else if (state == SH_DR)  dr_sh <= dr_next;
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST)                 TDO <= 1'b0;
        else if (state == SH_DR)  TDO <= dr_sh[0];
        else if (state == SH_IR)  TDO <= ir_sh[0];
        else                      TDO <= 1'b0;
    end

    // DMI bridge events
    assign upd_dtmcs = (state == UPD_DR) && (dr_sel == DR_DTMCS);
    assign upd_dmi   = (state == UPD_DR) && (dr_sel == DR_DMI);
    assign cap_dmi   = (state == CAP_DR) && (dr_sel == DR_DMI);
    assign dmireset  = upd_dtmcs && dr_sh[16];
    assign hardreset = upd_dtmcs && dr_sh[17];
    assign busy_evt  = outstanding && (cap_dmi || upd_dmi);
    assign resp_hs   = dmi_resp_valid && dmi_resp_ready && !hardreset;
    assign fail_evt  = resp_hs && (dmi_resp_op == 2'd2);
    assign start     = upd_dmi && !outstanding && (dmistat == 2'd0) &&
                       ((dr_sh[1:0] == 2'd1) || (dr_sh[1:0] == 2'd2));

    assign dmi_resp_ready = outstanding && req_accepted;

    // Sticky status: busy outranks failed, only a reset clears it
    always_comb begin
        dmistat_base = (dmireset || hardreset) ? 2'd0 : dmistat;
        dmistat_next = dmistat_base;
        if (busy_evt)                           dmistat_next = 2'd3;
        else if (fail_evt && dmistat_base != 2'd3) dmistat_next = 2'd2;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            outstanding   <= 1'b0;
            req_accepted  <= 1'b0;
            dmistat       <= 2'd0;
            resp_data     <= '0;
        end else begin
            dmistat <= dmistat_next;
            if (hardreset) begin
                dmi_req_valid <= 1'b0;
                outstanding   <= 1'b0;
                req_accepted  <= 1'b0;
            end else begin
                if (start) begin
                    dmi_req_valid <= 1'b1;
                    dmi_req_addr  <= dr_sh[DRW-1:34];
                    dmi_req_data  <= dr_sh[33:2];
                    dmi_req_op    <= dr_sh[1:0];
                    outstanding   <= 1'b1;
                    req_accepted  <= 1'b0;
                end
                if (dmi_req_valid && dmi_req_ready) begin
                    dmi_req_valid <= 1'b0;
                    req_accepted  <= 1'b1;
                end
                if (resp_hs) begin
                    resp_data    <= dmi_resp_data;
                    outstanding  <= 1'b0;
                    req_accepted <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/jtag_dtm_param.md
JTAG_DTM_PARAM -- requirements
Module: jtag_dtm_param

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 5, meaning instruction register width (min 5).
REQ-002 SHALL provide parameter ABITS, default 7, meaning DMI address width (1..63).
REQ-003 SHALL provide parameter IDCODE_VAL, default 32'h0000_0001, meaning the IDCODE value; bit0 is forced to 1.
REQ-004 SHALL provide parameter IDLE_HINT, default 5, meaning the 3-bit DTMCS idle field.
REQ-005 SHALL provide port TCK, input, 1, JTAG clock; all logic runs in the TCK domain.
REQ-006 SHALL provide port TRST, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL provide ports TMS input 1 and TDI input 1, both sampled on the rising edge of TCK.
REQ-008 SHALL provide port TDO, output, 1, serial data out, driven on the falling edge of TCK.
REQ-009 SHALL provide ports dmi_req_valid out 1, dmi_req_ready in 1, dmi_req_addr out ABITS, dmi_req_data out 32, dmi_req_op out 2.
REQ-010 SHALL provide ports dmi_resp_valid in 1, dmi_resp_ready out 1, dmi_resp_data in 32, dmi_resp_op in 2.

Function
REQ-011 SHALL implement the 16-state IEEE 1149.1 TAP FSM; Test-Logic-Reset goes to Run-Test/Idle on TMS=0; five TMS=1 clocks from any state reach Test-Logic-Reset.
REQ-012 SHALL load IR with IDCODE (5'b00001, zero-extended) in Test-Logic-Reset, load the shift value ...01 in Capture-IR, and update IR in Update-IR.
REQ-013 SHALL select the DR as: 0x01 IDCODE (32 b), 0x10 DTMCS (32 b), 0x11 DMI (ABITS+34 b), all other codes BYPASS (1 b, captures 0).
REQ-014 SHALL shift LSB first: TDI enters the MSB of the selected register length; TDO = shift LSB in Shift-IR/DR, else 0.
REQ-015 SHALL capture DTMCS as {14'b0, dmihardreset=0, dmireset=0, 1'b0, IDLE_HINT, dmistat, ABITS[5:0], version=4'd1}.
REQ-016 SHALL, on Update-DR of DTMCS, clear dmistat when bit16 is 1; when bit17 is 1, also clear the outstanding flag and deassert dmi_req_valid on the next edge.
REQ-017 SHALL format DMI as {addr[ABITS-1:0], data[31:0], op[1:0]}; write op 0=nop, 1=read, 2=write; capture op 0=ok, 2=failed, 3=busy.
REQ-018 SHALL capture DMI as {last addr, last resp data, dmistat}; if a request is outstanding, it SHALL capture op=3 and set dmistat=3.
REQ-019 SHALL, on Update-DR of DMI with dmistat=0, no outstanding request, and op 1 or 2, register addr/data/op, assert dmi_req_valid on the next rising edge, and set outstanding.
REQ-020 SHALL ignore Update-DR DMI when op=0 or dmistat!=0; when a request is outstanding, it SHALL ignore the update and set dmistat=3.
REQ-021 SHALL hold dmi_req_valid and its payload stable until the cycle with dmi_req_ready=1, then deassert it.
REQ-022 SHALL assert dmi_resp_ready only while outstanding and req already accepted; on a resp handshake it SHALL store data, clear outstanding, and set dmistat=2 if resp op=2.
REQ-023 SHALL keep dmistat sticky (never downgraded except by dmireset); when a busy event and a failed response occur in the same cycle, dmistat=3.
REQ-024 SHALL give a dmihardreset coinciding with a resp handshake priority: the response is discarded.

Reset
REQ-025 SHALL, on TRST high, immediately set tap=Test-Logic-Reset, IR=IDCODE, shift=0, TDO=0, dmi_req_valid=0, dmi_resp_ready=0, outstanding=0, dmistat=0, stored addr/data=0.
REQ-026 SHALL abandon a TRST asserted mid-transaction without completion; dmi_resp_valid arriving while not outstanding SHALL be ignored.

Verification
REQ-027 SHALL be verified as: TRST, then shift IDCODE DR 32 b -> TDO stream equals IDCODE_VAL LSB first; IR capture shows ...01.
REQ-028 SHALL be verified as: read DTMCS with ABITS=7 -> 0x0000_5071.
REQ-029 SHALL be verified as: DMI write addr 0x10 data 0xDEADBEEF op 2, ready after 3 TCK, resp op 0 -> req payload exact; next DMI capture = {0x10, resp data, 0}.
REQ-030 SHALL be verified as: DMI update while outstanding (ready held 0) -> capture op=3; further updates produce no new request; DTMCS bit16 write -> dmistat=0.
REQ-031 SHALL be verified as: resp op=2 -> DTMCS dmistat=2; dmihardreset during outstanding -> dmi_req_valid drops next edge, outstanding=0.
REQ-032 SHALL be verified as: five TMS=1 from Shift-DR -> Test-Logic-Reset, IR=0x01; BYPASS with IR=0x1F -> TDI delayed exactly 1 TCK on TDO.
